fetch_debug_ctrl: RTL

- Control block directly upstream of the instruction-fetch stage.
- Receives a byte stream from the UART receiver and assembles 32-bit instruction words, which it writes into instruction memory.
- Drives the fetch stage's PC enable, PC reset and memory read-enable, so the program can be run continuously or single-stepped.
- Detects the HALT instruction at the fetch output and reports program completion.

---
 rtl/fetch_debug_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_debug_ctrl.sv
// Fetch-stage debug controller: UART byte loader into instruction memory, run/step PC control, HALT detection.
// Optional cycle counter output enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_debug_ctrl #(
    parameter int                          NB_DATA        = 8,
    parameter int                          NB_INSTRUCTION = 32,
    parameter int                          NB_ADDR        = 32,
    parameter int                          IMEM_DEPTH     = 256,
    parameter logic [NB_INSTRUCTION-1:0]   HALT_WORD      = 32'hFFFFFFFF
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NB_DATA-1:0]        i_rx_data,
    input  logic                      i_rx_valid,
    input  logic [NB_INSTRUCTION-1:0] i_instruction,
    output logic                      o_imem_wr_en,
    output logic [NB_ADDR-1:0]        o_imem_wr_addr,
    output logic [NB_INSTRUCTION-1:0] o_imem_wr_data,
    output logic                      o_pc_enable,
    output logic                      o_pc_reset,
    output logic                      o_read_enable,
    output logic                      o_program_done,
`ifdef FETCH_CYCLE_COUNT_EN
    output logic [31:0]               o_cycle_count,
`endif
    output logic [2:0]                o_state
);

    localparam int BPW   = NB_INSTRUCTION / NB_DATA;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CNT_W = $clog2(IMEM_DEPTH + 1);
    localparam int PW    = NB_INSTRUCTION - NB_DATA;

    localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(BPW - 1);
    localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(NB_INSTRUCTION / 8);
    localparam logic [NB_DATA-1:0] CMD_L = NB_DATA'(8'h4C);
    localparam logic [NB_DATA-1:0] CMD_C = NB_DATA'(8'h43);
    localparam logic [NB_DATA-1:0] CMD_S = NB_DATA'(8'h53);
    localparam logic [NB_DATA-1:0] CMD_N = NB_DATA'(8'h4E);
    localparam logic [NB_DATA-1:0] CMD_R = NB_DATA'(8'h52);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        READY     = 3'd2,
        RUN       = 3'd3,
        STEP_WAIT = 3'd4,
        STEP_EXEC = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             word_q, word_d;
    logic [BC_W-1:0]           byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic [NB_ADDR-1:0]        addr_q, addr_d;
    logic                      loaded_q, loaded_d;
    logic                      wr_en_q, wr_en_d;
    logic [NB_ADDR-1:0]        wr_addr_q, wr_addr_d;
    logic [NB_INSTRUCTION-1:0] wr_data_q, wr_data_d;
    logic [NB_INSTRUCTION-1:0] full_word;
    logic                      is_halt;
    logic                      start_load;

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        byte_cnt_d     = byte_cnt_q;
        word_cnt_d     = word_cnt_q;
        addr_d         = addr_q;
        loaded_d       = loaded_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        start_load     = 1'b0;
        o_pc_enable    = 1'b0;
        o_pc_reset     = 1'b0;
        o_read_enable  = 1'b0;
        o_program_done = 1'b0;
        full_word      = {word_q, i_rx_data};
        is_halt        = (i_instruction == HALT_WORD);

        case (state_q)
            IDLE: begin
                o_pc_reset = 1'b1;
                if (i_rx_valid && i_rx_data == CMD_L) start_load = 1'b1;
            end
            LOAD: begin
                o_pc_reset = 1'b1;
                if (i_rx_valid) begin
                    word_d = full_word[PW-1:0];
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = full_word;
                        addr_d     = addr_q + ADDR_STEP;
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        // The final word and the move to READY land on the same edge.
                        if (full_word == HALT_WORD || word_cnt_d == CNT_W'(IMEM_DEPTH)) begin
                            state_d  = READY;
                            loaded_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            READY: begin
                o_pc_reset = 1'b1;
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_L)                  start_load = 1'b1;
                    else if (i_rx_data == CMD_C && loaded_q) state_d = RUN;
                    else if (i_rx_data == CMD_S && loaded_q) state_d = STEP_WAIT;
                end
            end
            RUN: begin
                o_read_enable = 1'b1;
                o_pc_enable   = !is_halt;
                if (is_halt) state_d = DONE;
            end
            STEP_WAIT: begin
                o_read_enable = 1'b1;
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_N)      state_d = is_halt ? DONE : STEP_EXEC;
                    else if (i_rx_data == CMD_C) state_d = RUN;
                end
            end
            STEP_EXEC: begin
                o_read_enable = 1'b1;
                o_pc_enable   = 1'b1;
                state_d       = STEP_WAIT;
            end
            DONE: begin
                o_program_done = 1'b1;
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_R)      state_d = READY;
                    else if (i_rx_data == CMD_L) start_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_load) begin
            state_d    = LOAD;
            addr_d     = '0;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            loaded_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            loaded_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            loaded_q   <= loaded_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Partial word is never read while the byte counter is zero, so it needs no reset.
    always_ff @(posedge i_clock) begin
        word_q <= word_d;
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            cycle_cnt_q <= '0;
        end else if (state_q == READY && (state_d == RUN || state_d == STEP_WAIT)) begin
            cycle_cnt_q <= '0;
        end else if (o_pc_enable && cycle_cnt_q != 32'hFFFFFFFF) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign o_cycle_count = cycle_cnt_q;
`endif

    assign o_imem_wr_en   = wr_en_q;
    assign o_imem_wr_addr = wr_addr_q;
    assign o_imem_wr_data = wr_data_q;
    assign o_state        = state_q;

endmodule
